// File: rtl/ret_addr_stack.sv
// ret_addr_stack -- return address stack for fetch-side PC prediction.
//
// A fetched ICALL speculatively pushes its fall-through PC; a fetched IRET
// pops it and offers it as the predicted return target. A committed
// pointer/count shadow follows writeback. flush_i restores the speculative
// pointer/count from the committed ones. Entry data is not checkpointed.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   f_icode_i         fetch-stage icode
//   f_valP_i          fetch-stage fall-through PC (pushed return address)
//   f_stall_i         fetch held: no speculative push/pop
//   W_icode_i         writeback-stage icode (advances committed state)
//   flush_i           restore speculative state from committed state
//   f_ras_valid_o     prediction valid (IRET fetched and stack non-empty)
//   f_ras_target_o    predicted return PC, 0 when not valid
//   ras_empty_o       speculative count is zero
//   ras_full_o        speculative count equals DEPTH
//   ras_ovf_cnt_o     (only with `define RAS_OVF_CNT_EN) saturating count of
//                     pushes made while full
//
// Optional feature macro: RAS_OVF_CNT_EN.

`ifndef INOP
`define INOP  4'h1
`endif
`ifndef ICALL
`define ICALL 4'h8
`endif
`ifndef IRET
`define IRET  4'h9
`endif

module ret_addr_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = $clog2(DEPTH),
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  f_icode_i,
    input  logic [63:0] f_valP_i,
    input  logic        f_stall_i,
    input  logic [3:0]  W_icode_i,
    input  logic        flush_i,
    output logic        f_ras_valid_o,
    output logic [63:0] f_ras_target_o,
    output logic        ras_empty_o,
`ifdef RAS_OVF_CNT_EN
    output logic [15:0] ras_ovf_cnt_o,
`endif
    output logic        ras_full_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [63:0]      mem_q [DEPTH];

    logic [PTR_W-1:0] spec_top_q,   spec_top_d;
    logic [CNT_W-1:0] spec_cnt_q,   spec_cnt_d;
    logic [PTR_W-1:0] commit_top_q, commit_top_d;
    logic [CNT_W-1:0] commit_cnt_q, commit_cnt_d;

    logic             push_en;
    logic             pop_en;
    logic [PTR_W-1:0] rd_ptr;

    // Outputs are a pure function of current state and the fetched icode,
    // so they keep tracking f_icode_i while fetch is stalled.
    always_comb begin
        rd_ptr         = spec_top_q - PTR_W'(1);
        ras_empty_o    = (spec_cnt_q == '0);
        ras_full_o     = (spec_cnt_q == CNT_MAX);
        f_ras_valid_o  = (f_icode_i == `IRET) && !ras_empty_o;
        f_ras_target_o = f_ras_valid_o ? mem_q[rd_ptr] : '0;
    end

    // Flush wins over a same-cycle fetch push/pop, which is simply dropped.
    always_comb begin
        push_en = (f_icode_i == `ICALL) && !f_stall_i && !flush_i;
        pop_en  = (f_icode_i == `IRET)  && !f_stall_i && !flush_i && !ras_empty_o;
    end

    always_comb begin
        commit_top_d = commit_top_q;
        commit_cnt_d = commit_cnt_q;
        if (W_icode_i == `ICALL) begin
            commit_top_d = commit_top_q + PTR_W'(1);
            if (commit_cnt_q != CNT_MAX) begin
                commit_cnt_d = commit_cnt_q + CNT_W'(1);
            end
        end else if ((W_icode_i == `IRET) && (commit_cnt_q != '0)) begin
            commit_top_d = commit_top_q - PTR_W'(1);
            commit_cnt_d = commit_cnt_q - CNT_W'(1);
        end
    end

    // Flush restores from the *next* committed state so a commit landing in
    // the same cycle is not lost.
    always_comb begin
        spec_top_d = spec_top_q;
        spec_cnt_d = spec_cnt_q;
        if (flush_i) begin
            spec_top_d = commit_top_d;
            spec_cnt_d = commit_cnt_d;
        end else if (push_en) begin
            spec_top_d = spec_top_q + PTR_W'(1);
            if (!ras_full_o) begin
                spec_cnt_d = spec_cnt_q + CNT_W'(1);
            end
        end else if (pop_en) begin
            spec_top_d = spec_top_q - PTR_W'(1);
            spec_cnt_d = spec_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            spec_top_q   <= '0;
            spec_cnt_q   <= '0;
            commit_top_q <= '0;
            commit_cnt_q <= '0;
        end else begin
            spec_top_q   <= spec_top_d;
            spec_cnt_q   <= spec_cnt_d;
            commit_top_q <= commit_top_d;
            commit_cnt_q <= commit_cnt_d;
        end
    end

    // Storage is not reset; entries are only meaningful below spec_cnt.
    // When full, the push overwrites the oldest entry.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[spec_top_q] <= f_valP_i;
        end
    end

`ifdef RAS_OVF_CNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (push_en && ras_full_o && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ras_ovf_cnt_o = ovf_cnt_q;
`endif

endmodule
